periferico_hs_multi: RTL
========================

# periferico_hs_multi

Parametrised receive-side peripheral for the send/ack four-phase handshake. It generalises the single-channel, 3-bit peripheral FSM to N independent producer channels of W-bit data. Each `send` input passes through a synchroniser, and pending channels are served by a round-robin arbiter. Captured words go, tagged with their channel, into a DEPTH-entry FIFO drained by a valid/ready read port. The block sits between one or more CPU-side FSMs, which may run on other clocks, and the consuming logic.

## Interface
- `N`, 4, number of producer channels (≥1)
- `W`, 3, data width per channel
- `DEPTH`, 8, FIFO entries, power of two, ≥2
- `SYNC_STAGES`, 2, flops on each `send` input (≥2)
- `CW`, derived, `max(1, clog2(N))`, channel-id width
- `clk1` in 1: single clock; all logic rises on it
- `rst1` in 1: reset, synchronous, active-low
- `send` in N: per-channel request, asynchronous to `clk1`
- `data` in N*W: channel i occupies bits `[i*W +: W]`; stable whenever `send[i]`=1
- `ack` out N: per-channel acknowledge, registered, at most one bit high
- `rd_data` out W: FIFO head data
- `rd_chan` out CW: FIFO head channel id
- `rd_valid` out 1: FIFO non-empty
- `rd_ready` in 1: consumer accepts head when `rd_valid` is high
- `count` out `clog2(DEPTH+1)`: current FIFO occupancy

## Operation
- **Synchroniser:** `send_s[i]` is `send[i]` delayed by `SYNC_STAGES` flops. All control uses `send_s`.
- **FSM states:**
  - **IDLE:** `ack`=0. If any `send_s[i]`=1 and `count`<DEPTH:
    - grant the first requesting channel in the order `ptr`, `ptr+1`, …, `ptr+N-1` (mod N);
    - push `{i, data[i]}` into the FIFO;
    - set `ack[i]`=1, record `gnt`=i;
    - go to ACK.
  - Otherwise stay in IDLE.
- **ACK:** `ack[gnt]`=1. When `send_s[gnt]`=0:
  - clear `ack`;
  - set `ptr` ← `gnt+1` (mod N);
  - go to IDLE.
- **FIFO full:** no grant and no `ack`. Producers stall with `send` high (backpressure). No data is dropped.
- **Read:** pop on `rd_valid && rd_ready`.
- **Simultaneous push and pop:** both happen; `count` is unchanged.
- **Push when full at the same edge as a pop:** not permitted. The full check uses the pre-edge `count`.
- **Pointers:** FIFO read and write pointers wrap modulo DEPTH. `ptr` wraps modulo N.
- **Data path:** `data[i]` is sampled unsynchronised at grant. This is safe because the protocol holds data stable while `send` is high.
- **Reset** (`rst1`=0 at an edge), including mid-handshake:
  - state=IDLE, `ack`=0, `ptr`=0;
  - FIFO empty (`count`=0, `rd_valid`=0);
  - synchronisers cleared.
  - A producer still holding `send` high after reset is captured again; the duplicate is accepted behaviour.

## Timing
- **Reset values:** `ack`=0, `rd_valid`=0, `count`=0. `rd_data` and `rd_chan` are don't-care.
- **Request to ack:** `send[i]` rising before edge k → `send_s[i]` high after edge k+SYNC_STAGES-1 → grant, push and `ack[i]` high after edge k+SYNC_STAGES.
- **Push to read port:** the entry is visible on `rd_valid` in the cycle after the push edge.
- **Ack release:** `send[i]` falling → `ack[i]` low `SYNC_STAGES`+1 edges later.
- **Next grant:** may occur at the first edge after `ack` falls. Each transfer occupies at least 2 IDLE/ACK edges plus both synchroniser delays.
- **Combinational paths:** none from inputs to outputs. `rd_data`/`rd_chan` are driven straight from FIFO storage.

## Structure
- **Package `periferico_pkg`:** holds the state enum (IDLE, ACK) and a `clog2` helper function used for `CW` and `count` widths.
- **Sub-module `fifo_sync`:** parameters `W+CW` and DEPTH; ports push, pop, full, empty, count. It is reused elsewhere.
- Synchroniser, arbiter and FSM stay in the top module.

## Test plan
- **Single transfer:** N=4, W=3, channel 2 sends 3'b101 → after SYNC_STAGES+1 edges `ack`=4'b0100. Drop `send` → `ack` clears. Read port shows data 5, chan 2.
- **Round robin:** channels 0, 1, 3 request together and hold each request until acked, then drop → grant order 0, 1, 3. Repeat with `ptr`=1 → order 1, 3, 0.
- **Full backpressure:** `rd_ready`=0, DEPTH=8, 9 transfers on channel 0 → 8 complete with `count`=8. The ninth sees no `ack` until one read, then completes with `count`=8.
- **Concurrent push/pop:** `count`=3, `rd_ready`=1 on the push edge → `count` stays 3 and the FIFO order is preserved.
- **Reset mid-ACK:** `rst1`=0 while `ack[1]`=1 → the next edge gives `ack`=0 and `count`=0. After release, the held `send[1]` is re-captured once.
- **Wrap:** 20 transfers through DEPTH=8 with continuous reads → all 20 values read in order with correct channel ids.

Source files
------------

// File: rtl/periferico_pkg.sv
// Shared types and helpers for the multi-channel send/ack handshake peripheral.
package periferico_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count; storage is not reset, only pointers and count.
module fifo_sync
    import periferico_pkg::*;
#(
    parameter int DW    = 5,
    parameter int DEPTH = 8,
    localparam int AW   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CNTW = clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [DW-1:0]   din,
    output logic [DW-1:0]   dout,
    output logic            full,
    output logic            empty,
    output logic [CNTW-1:0] count
);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CNTW-1:0] r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == CNTW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CNTW'(w_do_push) - CNTW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/periferico_hs_multi.sv
// N-channel receive side of the send/ack four-phase handshake: synchronise, round-robin
// arbitrate, and queue {channel, data} words for a valid/ready consumer.
module periferico_hs_multi
    import periferico_pkg::*;
#(
    parameter int N           = 4,
    parameter int W           = 3,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = (clog2(N) < 1) ? 1 : clog2(N),
    localparam int CNTW       = clog2(DEPTH + 1)
) (
    input  logic            clk1,
    input  logic            rst1,
    input  logic [N-1:0]    send,
    input  logic [N*W-1:0]  data,
    output logic [N-1:0]    ack,
    output logic [W-1:0]    rd_data,
    output logic [CW-1:0]   rd_chan,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [CNTW-1:0] count
);

    logic [SYNC_STAGES-1:0][N-1:0] r_sync;
    logic [N-1:0]   w_send_s;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_ptr;
    logic [CW-1:0]  w_ptr_nxt;
    logic [CW-1:0]  r_gnt;
    logic [CW-1:0]  w_gnt_nxt;
    logic [N-1:0]   r_ack;
    logic [N-1:0]   w_ack_nxt;

    logic           w_req_any;
    logic [CW-1:0]  w_sel;
    logic           w_grant;
    logic           w_release;
    logic [W-1:0]   w_push_data;
    logic           w_full;
    logic           w_empty;
    logic [W+CW-1:0] w_dout;

    always_ff @(posedge clk1) begin
        if (!rst1) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], send};
    end

    assign w_send_s = r_sync[SYNC_STAGES-1];

    // First requester at or after r_ptr, searching upward modulo N.
    always_comb begin
        int k;
        k         = 0;
        w_req_any = 1'b0;
        w_sel     = '0;
        for (int j = 0; j < N; j++) begin
            k = (int'(r_ptr) + j) % N;
            if (!w_req_any && w_send_s[CW'(k)]) begin
                w_req_any = 1'b1;
                w_sel     = CW'(k);
            end
        end
    end

    // Full check uses the pre-edge count, so a same-edge pop never frees a slot.
    assign w_grant     = (r_state == S_IDLE) && w_req_any && !w_full;
    assign w_release   = (r_state == S_ACK) && !w_send_s[r_gnt];
    assign w_push_data = data[int'(w_sel)*W +: W];

    always_ff @(posedge clk1) begin
        if (!rst1) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant)   w_state_nxt = S_ACK;
            S_ACK:   if (w_release) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ack_nxt = r_ack;
        w_gnt_nxt = r_gnt;
        w_ptr_nxt = r_ptr;
        if (w_grant) begin
            w_ack_nxt        = '0;
            w_ack_nxt[w_sel] = 1'b1;
            w_gnt_nxt        = w_sel;
        end
        if (w_release) begin
            w_ack_nxt = '0;
            w_ptr_nxt = (int'(r_gnt) == N - 1) ? '0 : r_gnt + CW'(1);
        end
    end

    fifo_sync #(
        .DW    (W + CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk1),
        .rst_n (rst1),
        .push  (w_grant),
        .pop   (rd_valid && rd_ready),
        .din   ({w_sel, w_push_data}),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (count)
    );

    assign ack      = r_ack;
    assign rd_valid = !w_empty;
    assign rd_chan  = w_dout[W +: CW];
    assign rd_data  = w_dout[W-1:0];

endmodule
